// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared slave.
interface wb_arbiter_if #(
  parameter int AddrSz = 4,
  parameter int DataSz = 8,
  parameter int NReq   = 2
);
  import wb_arbiter_pkg::*;

  // Handshake: a requester raises m_stb_i and holds it, with stable we/adr/dat,
  // until it sees m_ack_o or m_err_o for one cycle; the slave completes a
  // transfer by raising s_ack_i while s_stb_o is high (same cycle allowed).
  logic [NReq-1:0]        m_stb_i;
  logic [NReq-1:0]        m_we_i;
  logic [NReq*AddrSz-1:0] m_adr_i;
  logic [NReq*DataSz-1:0] m_dat_i;
  logic [NReq-1:0]        m_ack_o;
  logic [NReq-1:0]        m_err_o;
  logic [NReq*DataSz-1:0] m_dat_o;
  logic                   s_stb_o;
  logic                   s_we_o;
  logic [AddrSz-1:0]      s_adr_o;
  logic [DataSz-1:0]      s_dat_o;
  logic                   s_ack_i;
  logic [DataSz-1:0]      s_dat_i;
  logic [NReq-1:0]        gnt_o;
  state_e                 state;

  modport slave (
    input  m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output gnt_o, state
  );

  modport master (
    output m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  gnt_o, state
  );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NReq = 2,
  parameter int IW   = 1
) (
  input  logic [NReq-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  int            pos;
  logic [IW-1:0] idx;

  // Scan from the farthest candidate down so the nearest one after 'last' wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    pos    = 0;
    idx    = '0;
    for (int k = NReq; k >= 1; k--) begin
      pos = (int'(last) + k) % NReq;
      idx = IW'(pos);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave between NReq requesters,
// with a per-transfer timeout that returns err when the slave never acks.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int AddrSz     = 4,
  parameter int DataSz     = 8,
  parameter int NReq       = 2,
  parameter int TimeoutCyc = 15
) (
  input logic          clk_i,
  input logic          rst_i,
  wb_arbiter_if.slave  bus
);

  localparam int            IW       = idx_width(NReq);
  localparam int            CW       = (TimeoutCyc > 0) ? $clog2(TimeoutCyc + 1) : 1;
  localparam bit            TO_EN    = (TimeoutCyc != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TimeoutCyc > 0) ? TimeoutCyc - 1 : 0);

  state_e         state_q, state_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [NReq-1:0]        ack, err, gnt;
  logic [NReq*DataSz-1:0] m_dat;
  logic                   s_stb, s_we;
  logic [AddrSz-1:0]      s_adr;
  logic [DataSz-1:0]      s_dat;

  rr_pick #(.NReq(NReq), .IW(IW)) u_pick (
    .req    (bus.m_stb_i),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // last_q starts at NReq-1 so requester 0 has first priority after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(NReq - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack     = '0;
    err     = '0;
    gnt     = '0;
    m_dat   = '0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        gnt[gnt_q] = 1'b1;
        s_stb      = bus.m_stb_i[gnt_q];
        s_we       = bus.m_we_i[gnt_q];
        s_adr      = bus.m_adr_i[int'(gnt_q)*AddrSz +: AddrSz];
        s_dat      = bus.m_dat_i[int'(gnt_q)*DataSz +: DataSz];
        // Priority: abort, then ack, then timeout, so an ack on the limit cycle wins.
        if (!bus.m_stb_i[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else if (bus.s_ack_i) begin
          ack[gnt_q]                          = 1'b1;
          m_dat[int'(gnt_q)*DataSz +: DataSz] = bus.s_dat_i;
          last_d                              = gnt_q;
          state_d                             = IDLE;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          err[gnt_q] = 1'b1;
          s_stb      = 1'b0;
          last_d     = gnt_q;
          state_d    = IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_ack_o = ack;
  assign bus.m_err_o = err;
  assign bus.m_dat_o = m_dat;
  assign bus.gnt_o   = gnt;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = s_we;
  assign bus.s_adr_o = s_adr;
  assign bus.s_dat_o = s_dat;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (NReq=2, TimeoutCyc=4) with a queued scoreboard.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        stb;
    logic        we;
    logic [3:0]  adr;
    logic [7:0]  sdat;
    logic [15:0] mdat;
    state_e      st;
  } obs_t;

  localparam int EW = $bits(obs_t);

  logic          clk;
  logic          rst;
  logic          ack_en;
  logic [7:0]    rdata;
  logic [EW-1:0] exp_q[$];
  int            n_vec;
  int            n_bad;

  wb_arbiter_if #(.AddrSz(4), .DataSz(8), .NReq(2)) bus ();

  wb_arbiter #(.AddrSz(4), .DataSz(8), .NReq(2), .TimeoutCyc(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Slave model: acks whenever enabled and a transfer is in progress.
  assign bus.s_ack_i = ack_en & (|bus.gnt_o);
  assign bus.s_dat_i = rdata;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_busy(input logic [1:0] gnt, input logic [1:0] ack,
                             input logic [1:0] err, input logic stb,
                             input logic we, input logic [3:0] adr,
                             input logic [7:0] sdat, input logic [15:0] mdat);
    obs_t e;
    e.gnt  = gnt;
    e.ack  = ack;
    e.err  = err;
    e.stb  = stb;
    e.we   = we;
    e.adr  = adr;
    e.sdat = sdat;
    e.mdat = mdat;
    e.st   = BUSY;
    exp_q.push_back(EW'(e));
  endtask

  task automatic check(input string name, input logic [EW-1:0] got,
                       input logic [EW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: a busy cycle pops the next queued expectation, an idle one must be all-zero.
  always @(negedge clk) begin
    obs_t o;
    o.gnt  = bus.gnt_o;
    o.ack  = bus.m_ack_o;
    o.err  = bus.m_err_o;
    o.stb  = bus.s_stb_o;
    o.we   = bus.s_we_o;
    o.adr  = bus.s_adr_o;
    o.sdat = bus.s_dat_o;
    o.mdat = bus.m_dat_o;
    o.st   = bus.state;
    if (bus.gnt_o != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL busy_unexpected @%0t: got %h expected idle", $time, EW'(o));
      end else begin
        check("busy", EW'(o), exp_q.pop_front());
      end
    end else begin
      check("idle", EW'(o), '0);
    end
  end

  // ---------------- driver ----------------
  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    ack_en      = 1'b0;
    rdata       = 8'h00;
    bus.m_stb_i = 2'b00;
    bus.m_we_i  = 2'b00;
    bus.m_adr_i = 8'h00;
    bus.m_dat_i = 16'h0000;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);

    // Contention: both strobe continuously, grants must alternate 0,1,0,1.
    expect_busy(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 4'h1, 8'h10, 16'h005A);
    expect_busy(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 4'h7, 8'h20, 16'h5A00);
    expect_busy(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 4'h1, 8'h10, 16'h005A);
    expect_busy(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 4'h7, 8'h20, 16'h5A00);
    bus.m_stb_i = 2'b11;
    bus.m_we_i  = 2'b01;
    bus.m_adr_i = {4'h7, 4'h1};
    bus.m_dat_i = {8'h20, 8'h10};
    rdata       = 8'h5A;
    ack_en      = 1'b1;
    wait_cyc(8);
    bus.m_stb_i = 2'b00;
    wait_cyc(1);

    // Single requester 0 write adr=2 dat=A5, zero-wait slave.
    expect_busy(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 4'h2, 8'hA5, 16'h0011);
    bus.m_stb_i = 2'b01;
    bus.m_we_i  = 2'b01;
    bus.m_adr_i = {4'h0, 4'h2};
    bus.m_dat_i = {8'h00, 8'hA5};
    rdata       = 8'h11;
    wait_cyc(2);
    bus.m_stb_i = 2'b00;
    wait_cyc(1);

    // Requester 1 read returns 0x3C on its slice only.
    expect_busy(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 4'h3, 8'h77, 16'h3C00);
    bus.m_stb_i = 2'b10;
    bus.m_we_i  = 2'b00;
    bus.m_adr_i = {4'h3, 4'h0};
    bus.m_dat_i = {8'h77, 8'h00};
    rdata       = 8'h3C;
    wait_cyc(2);
    bus.m_stb_i = 2'b00;
    wait_cyc(1);

    // Timeout: slave silent, err on the 4th busy cycle with strobe forced low.
    ack_en = 1'b0;
    repeat (3) expect_busy(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 4'h5, 8'h99, 16'h0000);
    expect_busy(2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 4'h5, 8'h99, 16'h0000);
    bus.m_stb_i = 2'b01;
    bus.m_we_i  = 2'b00;
    bus.m_adr_i = {4'h0, 4'h5};
    bus.m_dat_i = {8'h00, 8'h99};
    wait_cyc(5);
    bus.m_stb_i = 2'b00;
    wait_cyc(1);

    // Ack arriving on the limit cycle wins over the timeout.
    repeat (3) expect_busy(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 4'h6, 8'h77, 16'h0000);
    expect_busy(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 4'h6, 8'h77, 16'hC300);
    bus.m_stb_i = 2'b10;
    bus.m_adr_i = {4'h6, 4'h0};
    bus.m_dat_i = {8'h77, 8'h00};
    rdata       = 8'hC3;
    wait_cyc(4);
    ack_en = 1'b1;
    wait_cyc(1);
    bus.m_stb_i = 2'b00;
    wait_cyc(1);

    // Abort: requester 0 drops its strobe while granted.
    ack_en = 1'b0;
    expect_busy(2'b01, 2'b00, 2'b00, 1'b1, 1'b1, 4'h4, 8'hE1, 16'h0000);
    expect_busy(2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 4'h4, 8'hE1, 16'h0000);
    bus.m_stb_i = 2'b01;
    bus.m_we_i  = 2'b01;
    bus.m_adr_i = {4'h0, 4'h4};
    bus.m_dat_i = {8'h00, 8'hE1};
    wait_cyc(2);
    bus.m_stb_i = 2'b00;
    wait_cyc(2);

    // Reset mid-busy: outputs drop at once, requester 0 wins first afterwards.
    expect_busy(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 4'h8, 8'h55, 16'h0000);
    bus.m_stb_i = 2'b10;
    bus.m_we_i  = 2'b00;
    bus.m_adr_i = {4'h8, 4'h0};
    bus.m_dat_i = {8'h55, 8'h00};
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    expect_busy(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 4'h9, 8'h42, 16'h006E);
    expect_busy(2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 4'h8, 8'h55, 16'h6E00);
    bus.m_stb_i = 2'b11;
    bus.m_we_i  = 2'b01;
    bus.m_adr_i = {4'h8, 4'h9};
    bus.m_dat_i = {8'h55, 8'h42};
    rdata       = 8'h6E;
    ack_en      = 1'b1;
    rst         = 1'b0;
    wait_cyc(4);
    bus.m_stb_i = 2'b00;
    wait_cyc(3);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
